// File: rtl/rename_free_list.sv
// Purpose: circular free list of physical rename tags; up to 2 offered / 2 reclaimed per cycle, one flush checkpoint.
// Latency: offers are combinational from state; pops, pushes and flush restores are visible the cycle after.
// Backpressure: all-or-nothing offer returns tag 0 when the pair cannot be served; pushes into a full list are dropped.
module rename_free_list #(
    parameter int TAG_WIDTH = 6,
    parameter int FIRST_TAG = 32,
    parameter int NUM_TAGS  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 alloc_req,
    input  logic                       alloc_commit,
    output logic [TAG_WIDTH-1:0]       alloc_tag_0,
    output logic [TAG_WIDTH-1:0]       alloc_tag_1,
    input  logic                       checkpoint_save,
    input  logic                       checkpoint_slot,
    input  logic                       flush,
    input  logic [1:0]                 free_valid,
    input  logic [TAG_WIDTH-1:0]       free_tag_0,
    input  logic [TAG_WIDTH-1:0]       free_tag_1,
    output logic [$clog2(NUM_TAGS):0]  free_count,
    output logic                       overflow_err
);
    localparam int IDX_W = $clog2(NUM_TAGS);
    localparam int PTR_W = IDX_W + 1;

    logic [TAG_WIDTH-1:0] storage [NUM_TAGS];
    logic [PTR_W-1:0]     head, tail, ckpt_head;
    logic                 ckpt_valid;

    logic [PTR_W-1:0]     need, room, n_push;
    logic                 can_serve;
    logic [IDX_W-1:0]     head_idx, head_nxt_idx, tail_idx, tail_nxt_idx;
    logic                 want0, want1, acc0, acc1, drop;

    assign free_count   = tail - head;
    assign need         = PTR_W'(alloc_req[0]) + PTR_W'(alloc_req[1]);
    assign can_serve    = (need <= free_count);
    assign head_idx     = head[IDX_W-1:0];
    assign head_nxt_idx = head_idx + IDX_W'(1);

    always_comb begin
        alloc_tag_0 = '0;
        alloc_tag_1 = '0;
        if (can_serve) begin
            case (alloc_req)
                2'b01: alloc_tag_0 = storage[head_idx];
                2'b10: alloc_tag_1 = storage[head_idx];
                2'b11: begin
                    alloc_tag_0 = storage[head_idx];
                    alloc_tag_1 = storage[head_nxt_idx];
                end
                default: ;
            endcase
        end
    end

    // Room is judged against the occupancy at the start of the cycle; same-cycle pops do not make space.
    assign room         = PTR_W'(NUM_TAGS) - free_count;
    assign want0        = free_valid[0] && (free_tag_0 != '0);
    assign want1        = free_valid[1] && (free_tag_1 != '0);
    assign acc0         = want0 && (room != '0);
    assign acc1         = want1 && (room > PTR_W'(acc0));
    assign drop         = (want0 && !acc0) || (want1 && !acc1);
    assign n_push       = PTR_W'(acc0) + PTR_W'(acc1);
    assign tail_idx     = tail[IDX_W-1:0];
    assign tail_nxt_idx = tail_idx + IDX_W'(acc0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                storage[i] <= TAG_WIDTH'(FIRST_TAG + i);
            end
            head         <= '0;
            tail         <= PTR_W'(NUM_TAGS);
            ckpt_head    <= '0;
            ckpt_valid   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (acc0) storage[tail_idx]     <= free_tag_0;
            if (acc1) storage[tail_nxt_idx] <= free_tag_1;
            tail <= tail + n_push;
            if (drop) overflow_err <= 1'b1;

            // Flush wins over the resolver's commit and checkpoint in the same cycle.
            if (flush) begin
                if (ckpt_valid) begin
                    head       <= ckpt_head;
                    ckpt_valid <= 1'b0;
                end
            end else if (alloc_commit) begin
                if (can_serve) head <= head + need;
                if (checkpoint_save) begin
                    ckpt_head  <= head + (checkpoint_slot ? need : PTR_W'(alloc_req[0]));
                    ckpt_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rename_free_list.sv
// Bench for rename_free_list: directed vector table, hand-written corner sequences, and a
// randomized run against a queue-level model of the free pool, in-flight and speculative tags.
module tb_rename_free_list;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, fv;
    logic       commit, save, slot, flush;
    logic [5:0] ft0, ft1, t0, t1, cnt;
    logic       ovf;

    always #5 clk = ~clk;

    rename_free_list #(.TAG_WIDTH(6), .FIRST_TAG(32), .NUM_TAGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(req), .alloc_commit(commit),
        .alloc_tag_0(t0), .alloc_tag_1(t1),
        .checkpoint_save(save), .checkpoint_slot(slot), .flush(flush),
        .free_valid(fv), .free_tag_0(ft0), .free_tag_1(ft1),
        .free_count(cnt), .overflow_err(ovf)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic idle();
        req = 2'b00; commit = 0; save = 0; slot = 0; flush = 0;
        fv = 2'b00; ft0 = 6'd0; ft1 = 6'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        logic [1:0] req;
        logic       commit, save, slot, flush;
        logic [1:0] fv;
        int         ft0, ft1;
        int         e0, e1, ecnt;
        logic       eovf;
    } vec_t;

    vec_t tbl[12];

    // Model state for the randomized run
    int fl[$];       // free tags in offer order
    int spec[$];     // tags handed out after the live checkpoint
    int retire[$];   // tags handed out and safe to return
    bit mck;
    bit movf;

    initial begin
        idle();
        rst_n = 1'b0;

        // req, commit, save, slot, flush, fv, ft0, ft1, exp tag0, exp tag1, exp count, exp ovf
        tbl[0]  = '{2'b11, 1, 1, 0, 0, 2'b00,  0, 0, 32, 33, 32, 0};
        tbl[1]  = '{2'b11, 1, 0, 0, 0, 2'b00,  0, 0, 34, 35, 30, 0};
        tbl[2]  = '{2'b11, 1, 0, 0, 0, 2'b00,  0, 0, 36, 37, 28, 0};
        tbl[3]  = '{2'b11, 1, 0, 0, 1, 2'b01, 32, 0, 38, 39, 26, 0};
        tbl[4]  = '{2'b01, 0, 0, 0, 0, 2'b00,  0, 0, 33,  0, 32, 0};
        tbl[5]  = '{2'b10, 0, 0, 0, 0, 2'b00,  0, 0,  0, 33, 32, 0};
        tbl[6]  = '{2'b11, 1, 0, 0, 1, 2'b00,  0, 0, 33, 34, 32, 0};
        tbl[7]  = '{2'b11, 0, 0, 0, 0, 2'b00,  0, 0, 33, 34, 32, 0};
        tbl[8]  = '{2'b00, 0, 0, 0, 0, 2'b01, 50, 0,  0,  0, 32, 0};
        tbl[9]  = '{2'b00, 0, 0, 0, 0, 2'b00,  0, 0,  0,  0, 32, 1};
        tbl[10] = '{2'b11, 1, 0, 0, 0, 2'b00,  0, 0, 33, 34, 32, 1};
        tbl[11] = '{2'b01, 0, 0, 0, 0, 2'b00,  0, 0, 35,  0, 30, 1};

        do_reset();
        chk("reset_count", int'(cnt), 32);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_tag0_idle", int'(t0), 0);

        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; commit = tbl[i].commit; save = tbl[i].save;
            slot = tbl[i].slot; flush = tbl[i].flush; fv = tbl[i].fv;
            ft0 = 6'(tbl[i].ft0); ft1 = 6'(tbl[i].ft1);
            #1;
            chk($sformatf("vec%0d_tag0", i), int'(t0), tbl[i].e0);
            chk($sformatf("vec%0d_tag1", i), int'(t1), tbl[i].e1);
            chk($sformatf("vec%0d_count", i), int'(cnt), tbl[i].ecnt);
            chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(tbl[i].eovf));
            step();
        end
        idle();

        // Drain to one entry, then the all-or-nothing boundary
        do_reset();
        req = 2'b11; commit = 1;
        for (int k = 0; k < 15; k++) step();
        req = 2'b01;
        #1 chk("drain_tag0_62", int'(t0), 62);
        step();
        commit = 0; req = 2'b11;
        #1 chk("one_left_count", int'(cnt), 1);
        chk("one_left_pair_tag0", int'(t0), 0);
        chk("one_left_pair_tag1", int'(t1), 0);
        req = 2'b10;
        #1 chk("one_left_slot1_tag1", int'(t1), 63);
        chk("one_left_slot1_tag0", int'(t0), 0);
        commit = 1;
        step();
        commit = 0; req = 2'b01;
        #1 chk("empty_count", int'(cnt), 0);
        chk("empty_tag0", int'(t0), 0);

        // Frees into an empty list are not offered until the next cycle
        fv = 2'b11; ft0 = 6'd40; ft1 = 6'd41;
        #1 chk("free_same_cycle_tag0", int'(t0), 0);
        step();
        fv = 2'b00;
        #1 chk("free_next_tag0", int'(t0), 40);
        chk("free_next_count", int'(cnt), 2);
        req = 2'b11;
        #1 chk("free_next_tag1", int'(t1), 41);
        req = 2'b00; fv = 2'b01; ft0 = 6'd0;
        step();
        fv = 2'b00;
        #1 chk("zero_tag_dropped_count", int'(cnt), 2);
        chk("zero_tag_no_ovf", int'(ovf), 0);

        // Overflow is sticky until an asynchronous reset mid-stream
        do_reset();
        fv = 2'b01; ft0 = 6'd45;
        step();
        fv = 2'b00;
        #1 chk("ovf_set", int'(ovf), 1);
        chk("ovf_count_unchanged", int'(cnt), 32);
        step();
        chk("ovf_sticky", int'(ovf), 1);
        req = 2'b11; commit = 1;
        step();
        chk("pre_reset_count", int'(cnt), 30);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("async_reset_count", int'(cnt), 32);
        chk("async_reset_ovf", int'(ovf), 0);
        chk("async_reset_tag0", int'(t0), 32);
        @(posedge clk);
        #3 rst_n = 1'b1;
        commit = 0;
        step();
        chk("post_reset_tag0", int'(t0), 32);
        chk("post_reset_tag1", int'(t1), 33);
        chk("post_reset_count", int'(cnt), 32);

        // Randomized run against the queue model
        do_reset();
        fl.delete(); spec.delete(); retire.delete();
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        mck = 0; movf = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int need, e0, e1, size0, k, room, acc;
            int popped[2];
            bit ok;
            req    = 2'($urandom_range(0, 3));
            commit = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 19) == 0);
            need   = int'(req[0]) + int'(req[1]);
            ok     = (need <= fl.size());
            save   = commit && (ok || flush) && ($urandom_range(0, 3) == 0);
            slot   = 1'($urandom_range(0, 1));
            fv = 2'b00; ft0 = 6'd0; ft1 = 6'd0;
            for (int s = 0; s < 2; s++) begin
                int tg;
                tg = -1;
                if ($urandom_range(0, 99) < 35 && retire.size() > 0) begin
                    int idx;
                    idx = $urandom_range(0, retire.size() - 1);
                    tg = retire[idx];
                    retire.delete(idx);
                end else if ($urandom_range(0, 29) == 0) begin
                    tg = 0;
                end
                if (tg >= 0) begin
                    fv[s] = 1'b1;
                    if (s == 0) ft0 = 6'(tg); else ft1 = 6'(tg);
                end
            end
            #1;
            e0 = 0; e1 = 0;
            if (ok) begin
                if (req == 2'b11) begin e0 = fl[0]; e1 = fl[1]; end
                else if (req == 2'b01) e0 = fl[0];
                else if (req == 2'b10) e1 = fl[0];
            end
            chk("rand_tag0", int'(t0), e0);
            chk("rand_tag1", int'(t1), e1);
            chk("rand_count", int'(cnt), fl.size());
            chk("rand_ovf", int'(ovf), int'(movf));

            size0 = fl.size();
            if (flush) begin
                if (mck) begin
                    for (int j = spec.size() - 1; j >= 0; j--) fl.push_front(spec[j]);
                    spec.delete();
                    mck = 0;
                end
            end else if (commit && ok) begin
                for (int j = 0; j < need; j++) popped[j] = fl.pop_front();
                if (save) begin
                    k = slot ? need : int'(req[0]);
                    foreach (spec[j]) retire.push_back(spec[j]);
                    spec.delete();
                    mck = 1;
                    for (int j = 0; j < need; j++) begin
                        if (j < k) retire.push_back(popped[j]);
                        else spec.push_back(popped[j]);
                    end
                end else begin
                    for (int j = 0; j < need; j++) begin
                        if (mck) spec.push_back(popped[j]);
                        else retire.push_back(popped[j]);
                    end
                end
            end
            room = 32 - size0;
            acc = 0;
            for (int s = 0; s < 2; s++) begin
                int tg;
                tg = (s == 0) ? int'(ft0) : int'(ft1);
                if (fv[s] && tg != 0) begin
                    if (acc < room) begin
                        fl.push_back(tg);
                        acc++;
                    end else begin
                        movf = 1;
                    end
                end
            end
            step();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
